riscv_store_buffer: RTL and testbench

Store-side counterpart to the load path of the single-cycle RISC-V core. It accepts `sb`/`sh`/`sw` requests from the datapath and aligns data into byte lanes with a byte-enable mask. Requests queue in a small FIFO and drain to data memory over a valid/ack handshake. It sits between the datapath (`alu_out` as address, rs2 as data, funct3) and the data memory write port, and can optionally forward buffered bytes to subsequent loads.

---
 rtl/riscv_store_pkg.sv | 31 +++
 rtl/riscv_store_align.sv | 37 +++
 rtl/riscv_store_buffer.sv | 142 ++++++++++++++
 tb/tb_riscv_store_buffer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_store_pkg.sv
// +--------------------------------------------------------------------+
// | riscv_store_pkg: store-buffer types, funct3 codes, alignment check |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

package riscv_store_pkg;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  typedef struct packed {
    logic [29:0] addr_w;
    logic [31:0] data;
    logic [3:0]  be;
  } store_entry_t;

  // Illegal funct3 codes are reported through the same error path as misalignment.
  function automatic logic store_misaligned(input logic [2:0] funct3, input logic [1:0] addr);
    case (funct3)
      F3_SB:   store_misaligned = 1'b0;
      F3_SH:   store_misaligned = addr[0];
      F3_SW:   store_misaligned = |addr;
      default: store_misaligned = 1'b1;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/riscv_store_align.sv
// +--------------------------------------------------------------------+
// | riscv_store_align: places sb/sh/sw data into byte lanes with mask  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module riscv_store_align
  import riscv_store_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  input  logic [31:0] data,
  output logic [31:0] wd,
  output logic [3:0]  be,
  output logic        err
);

  always_comb begin
    wd  = data;
    be  = 4'hf;
    err = store_misaligned(funct3, addr);
    case (funct3)
      F3_SB: begin
        wd = {4{data[7:0]}};
        be = 4'b0001 << addr;
      end
      F3_SH: begin
        wd = {2{data[15:0]}};
        be = 4'b0011 << {addr[1], 1'b0};
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/riscv_store_buffer.sv
// +--------------------------------------------------------------------+
// | riscv_store_buffer: in-order store FIFO draining to data memory.   |
// | RISCV_STORE_BUF_FWD_EN enables load forwarding. Revision: 1.0      |
// +--------------------------------------------------------------------+
`default_nettype none

module riscv_store_buffer
  import riscv_store_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     st_valid,
  output logic                     st_ready,
  input  logic [31:0]              st_addr,
  input  logic [31:0]              st_data,
  input  logic [2:0]               st_funct3,
  output logic                     st_err,
  output logic                     mem_we,
  output logic [31:0]              mem_addr,
  output logic [31:0]              mem_wd,
  output logic [3:0]               mem_be,
  input  logic                     mem_ack,
  input  logic [31:0]              ld_addr,
  output logic                     ld_hit,
  output logic [31:0]              ld_data,
  output logic [3:0]               ld_be,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          st_err_q, st_err_d;
  store_entry_t  fifo_q [DEPTH];
  store_entry_t  head;

  logic [31:0] al_wd;
  logic [3:0]  al_be;
  logic        al_err;
  logic        full, accept, enq, deq;

  riscv_store_align u_align (
    .funct3 (st_funct3),
    .addr   (st_addr[1:0]),
    .data   (st_data),
    .wd     (al_wd),
    .be     (al_be),
    .err    (al_err)
  );

  // Full blocks acceptance even when the head drains in the same cycle.
  assign full   = (count_q == CW'(DEPTH));
  assign accept = st_valid && !full;
  assign enq    = accept && !al_err;
  assign deq    = (count_q != '0) && mem_ack;

  always_comb begin
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    count_d  = count_q;
    st_err_d = accept && al_err;
    if (enq) wptr_d = wptr_q + 1'b1;
    if (deq) rptr_d = rptr_q + 1'b1;
    case ({enq, deq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      st_err_q <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      st_err_q <= st_err_d;
    end
  end

  // Storage needs no reset: an entry is only observed while count covers it.
  always_ff @(posedge clk) begin
    if (enq) fifo_q[wptr_q] <= '{addr_w: st_addr[31:2], data: al_wd, be: al_be};
  end

  assign head     = fifo_q[rptr_q];
  assign empty    = (count_q == '0);
  assign st_ready = !full;
  assign st_err   = st_err_q;
  assign count    = count_q;
  assign mem_we   = !empty;
  assign mem_addr = empty ? 32'h0 : {head.addr_w, 2'b00};
  assign mem_wd   = empty ? 32'h0 : head.data;
  assign mem_be   = empty ? 4'h0  : head.be;

`ifdef RISCV_STORE_BUF_FWD_EN
  logic [PW-1:0] fwd_idx;
  logic [31:0]   fwd_data;
  logic [3:0]    fwd_be;
  logic          unused_ld;

  // Walk oldest to youngest so later stores overwrite earlier bytes.
  always_comb begin
    fwd_idx  = '0;
    fwd_data = '0;
    fwd_be   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = rptr_q + PW'(i);
      if ((CW'(i) < count_q) && (fifo_q[fwd_idx].addr_w == ld_addr[31:2])) begin
        for (int b = 0; b < 4; b++) begin
          if (fifo_q[fwd_idx].be[b]) fwd_data[8*b +: 8] = fifo_q[fwd_idx].data[8*b +: 8];
        end
        fwd_be = fwd_be | fifo_q[fwd_idx].be;
      end
    end
  end

  assign ld_hit    = |fwd_be;
  assign ld_data   = fwd_data;
  assign ld_be     = fwd_be;
  assign unused_ld = ^ld_addr[1:0];
`else
  logic unused_ld;

  assign ld_hit    = 1'b0;
  assign ld_data   = 32'h0;
  assign ld_be     = 4'h0;
  assign unused_ld = ^ld_addr;
`endif

endmodule

`default_nettype wire

// File: tb/tb_riscv_store_buffer.sv
// +--------------------------------------------------------------------+
// | tb_riscv_store_buffer: vector table + scoreboard bench             |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_riscv_store_buffer;

  localparam int DEPTH = 4;
  localparam int NV    = 10;

  logic        clk, rst;
  logic        st_valid, st_ready;
  logic [31:0] st_addr, st_data;
  logic [2:0]  st_funct3;
  logic        st_err;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wd;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] ld_addr;
  logic        ld_hit;
  logic [31:0] ld_data;
  logic [3:0]  ld_be;
  logic        empty;
  logic [2:0]  count;

  riscv_store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
    .st_data(st_data), .st_funct3(st_funct3), .st_err(st_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_be(mem_be),
    .mem_ack(mem_ack), .ld_addr(ld_addr), .ld_hit(ld_hit),
    .ld_data(ld_data), .ld_be(ld_be), .empty(empty), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] wd;
    logic [3:0]  be;
    logic        err;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  be;
  } exp_t;

  vec_t vecs [NV];
  exp_t sb_q [$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
    sb_q.push_back('{addr: {a[31:2], 2'b00}, wd: wd, be: be});
  endtask

  task automatic drive_st(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    st_valid  = 1'b1;
    st_funct3 = f3;
    st_addr   = a;
    st_data   = d;
  endtask

  // Memory-side monitor: every accepted write must match the oldest expectation.
  always @(negedge clk) begin
    if (rst && mem_we && mem_ack) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_write: got addr %h expected no write", mem_addr);
      end else begin
        mon_e = sb_q.pop_front();
        chk("mem_addr", mem_addr, mon_e.addr);
        chk("mem_wd", mem_wd, mon_e.wd);
        chk("mem_be", {28'h0, mem_be}, {28'h0, mon_e.be});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{3'b010, 32'h08, 32'hdeadbeef, 32'hdeadbeef, 4'hf, 1'b0};
    vecs[1] = '{3'b000, 32'h13, 32'h000000a5, 32'ha5a5a5a5, 4'h8, 1'b0};
    vecs[2] = '{3'b001, 32'h16, 32'h0000c0de, 32'hc0dec0de, 4'hc, 1'b0};
    vecs[3] = '{3'b000, 32'h10, 32'h12345678, 32'h78787878, 4'h1, 1'b0};
    vecs[4] = '{3'b001, 32'h14, 32'habcd1234, 32'h12341234, 4'h3, 1'b0};
    vecs[5] = '{3'b000, 32'h11, 32'h00000099, 32'h99999999, 4'h2, 1'b0};
    vecs[6] = '{3'b010, 32'h06, 32'h01020304, 32'h0,        4'h0, 1'b1};
    vecs[7] = '{3'b111, 32'h00, 32'h01020304, 32'h0,        4'h0, 1'b1};
    vecs[8] = '{3'b001, 32'h15, 32'h0000beef, 32'h0,        4'h0, 1'b1};
    vecs[9] = '{3'b011, 32'h00, 32'h0000beef, 32'h0,        4'h0, 1'b1};

    rst = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0; st_funct3 = '0;
    mem_ack = 1'b0; ld_addr = '0;
    tick(); tick();
    chk("rst_st_ready", {31'h0, st_ready}, 32'h1);
    chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wd", mem_wd, 32'h0);
    chk("rst_mem_be", {28'h0, mem_be}, 32'h0);
    chk("rst_st_err", {31'h0, st_err}, 32'h0);
    chk("rst_empty", {31'h0, empty}, 32'h1);
    chk("rst_count", {29'h0, count}, 32'h0);
    chk("rst_ld", {27'h0, ld_hit, ld_be}, 32'h0);
    rst = 1'b1;
    tick();

    // Alignment / error table with memory always accepting.
    mem_ack = 1'b1;
    for (int k = 0; k < NV; k++) begin
      drive_st(vecs[k].f3, vecs[k].addr, vecs[k].data);
      chk("vec_st_ready", {31'h0, st_ready}, 32'h1);
      if (!vecs[k].err) push(vecs[k].addr, vecs[k].wd, vecs[k].be);
      tick();
      st_valid = 1'b0;
      chk("vec_st_err", {31'h0, st_err}, {31'h0, vecs[k].err});
      chk("vec_count", {29'h0, count}, vecs[k].err ? 32'h0 : 32'h1);
      chk("vec_mem_we", {31'h0, mem_we}, vecs[k].err ? 32'h0 : 32'h1);
      tick();
      chk("vec_st_err_pulse", {31'h0, st_err}, 32'h0);
      chk("vec_empty", {31'h0, empty}, 32'h1);
    end

    // Fill to full with memory stalled, then release.
    mem_ack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive_st(3'b010, 32'(k * 4), 32'h100 + 32'(k));
      push(32'(k * 4), 32'h100 + 32'(k), 4'hf);
      tick();
    end
    chk("full_st_ready", {31'h0, st_ready}, 32'h0);
    chk("full_count", {29'h0, count}, 32'h4);
    drive_st(3'b010, 32'h10, 32'h104);
    push(32'h10, 32'h104, 4'hf);
    tick();
    chk("full_hold_ready", {31'h0, st_ready}, 32'h0);
    chk("full_hold_count", {29'h0, count}, 32'h4);
    mem_ack = 1'b1;
    chk("full_no_bypass", {31'h0, st_ready}, 32'h0);
    tick();
    chk("after_deq_ready", {31'h0, st_ready}, 32'h1);
    chk("after_deq_count", {29'h0, count}, 32'h3);
    tick();
    st_valid = 1'b0;
    chk("enq_deq_count", {29'h0, count}, 32'h3);
    for (int n = 0; n < 20 && !empty; n++) tick();
    chk("full_drained", {31'h0, empty}, 32'h1);
    chk("full_sb_empty", 32'(sb_q.size()), 32'h0);

    // Forwarding probe against two stalled stores to the same word.
    mem_ack = 1'b0;
    drive_st(3'b010, 32'h20, 32'h11223344);
    push(32'h20, 32'h11223344, 4'hf);
    tick();
    drive_st(3'b000, 32'h21, 32'h000000ff);
    push(32'h21, 32'hffffffff, 4'h2);
    tick();
    st_valid = 1'b0;
    chk("fwd_count", {29'h0, count}, 32'h2);
    ld_addr = 32'h20;
    #1;
`ifdef RISCV_STORE_BUF_FWD_EN
    chk("fwd_hit", {31'h0, ld_hit}, 32'h1);
    chk("fwd_data", ld_data, 32'h1122ff44);
    chk("fwd_be", {28'h0, ld_be}, 32'hf);
    ld_addr = 32'h23;
    #1;
    chk("fwd_hit_lowbits", {31'h0, ld_hit}, 32'h1);
`else
    chk("nofwd_hit", {31'h0, ld_hit}, 32'h0);
    chk("nofwd_data", ld_data, 32'h0);
    chk("nofwd_be", {28'h0, ld_be}, 32'h0);
`endif
    ld_addr = 32'h24;
    #1;
    chk("fwd_miss", {31'h0, ld_hit}, 32'h0);
    mem_ack = 1'b1;
    for (int n = 0; n < 20 && !empty; n++) tick();
    chk("fwd_drained", 32'(sb_q.size()), 32'h0);

    // Reset in the middle of a drain drops everything queued.
    mem_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive_st(3'b010, 32'h40 + 32'(k * 4), 32'h5000 + 32'(k));
      push(32'h40 + 32'(k * 4), 32'h5000 + 32'(k), 4'hf);
      tick();
    end
    st_valid = 1'b0;
    chk("pre_rst_count", {29'h0, count}, 32'h3);
    mem_ack = 1'b1;
    tick();
    rst = 1'b0;
    sb_q.delete();
    #1;
    chk("mid_rst_count", {29'h0, count}, 32'h0);
    chk("mid_rst_mem_we", {31'h0, mem_we}, 32'h0);
    tick(); tick();
    rst = 1'b1;
    mem_ack = 1'b0;
    tick();
    drive_st(3'b010, 32'h80, 32'hcafef00d);
    push(32'h80, 32'hcafef00d, 4'hf);
    tick();
    st_valid = 1'b0;
    chk("post_rst_we", {31'h0, mem_we}, 32'h1);
    chk("post_rst_addr", mem_addr, 32'h80);
    chk("post_rst_wd", mem_wd, 32'hcafef00d);
    mem_ack = 1'b1;
    tick();
    chk("post_rst_empty", {31'h0, empty}, 32'h1);
    chk("final_sb_empty", 32'(sb_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
